jtag_stream_bridge: RTL and testbench



---
 rtl/jtag_stream_bridge_pkg.sv | 19 +
 rtl/jtag_stream_bridge_if.sv | 17 +
 rtl/jtag_stream_bridge_sync_fifo.sv | 51 +++++
 rtl/jtag_stream_bridge.sv | 108 ++++++++++
 tb/tb_jtag_stream_bridge.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtag_stream_bridge_pkg.sv
// Shared constants for the JTAG-to-stream bridge.
//   STATUS_WIDTH     : width of the optional status byte prefixed to the result
//   ST_*             : bit positions inside the status byte
//   bit_cnt_width()  : counter width able to hold 0 .. in_width+1
package jtag_bridge_pkg;

    localparam int STATUS_WIDTH    = 8;
    localparam int ST_RESULT_VALID = 0;
    localparam int ST_OVERFLOW     = 1;
    localparam int ST_EMPTY        = 2;
    localparam int ST_FULL         = 3;

    // The scan length counter saturates one past the word length, so it
    // has to represent in_width+1 distinct non-zero values.
    function automatic int bit_cnt_width(input int in_width);
        return $clog2(in_width + 2);
    endfunction

endpackage

// File: rtl/jtag_stream_bridge_if.sv
// Egress word stream of the bridge.
//   data  : head word (driven by master)
//   valid : head word present (driven by master)
//   ready : consumer accepts the head word (driven by slave)
// Handshake: a word moves on a rising clock edge where valid && ready.
// While valid is high and ready low, data holds stable; valid never
// depends combinationally on ready.
interface jtag_stream_bridge_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/jtag_stream_bridge_sync_fifo.sv
// Synchronous FIFO with pointer wrap bits for full/empty detection.
//   clk, rst_n : clock, synchronous active-low clear
//   push, push_data : write request and word
//   pop        : read request (ignored when empty)
//   pop_data   : head word, forced to 0 while empty
//   empty, full: occupancy flags
// A push while full is accepted only if a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Masking keeps the output at 0 after reset without clearing storage.
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/jtag_stream_bridge.sv
// JTAG USER DR to stream bridge.
//   tck, rst_n           : clock, synchronous active-low reset
//   test_logic_reset     : TAP in TLR, clears like rst_n
//   ir_is_user           : user DR selected, gates capture/shift/update
//   capture_dr, shift_dr, update_dr, tdi : TAP strobes and serial input
//   tdo                  : LSB of the readback shift register
//   m                    : egress word stream (master side)
//   result, result_valid : solver result loaded on every capture
module jtag_stream_bridge
    import jtag_bridge_pkg::*;
#(
    parameter int IN_WIDTH   = 8,
    parameter int OUT_WIDTH  = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int STATUS_EN  = 0
) (
    input  logic                  tck,
    input  logic                  rst_n,
    input  logic                  test_logic_reset,
    input  logic                  ir_is_user,
    input  logic                  capture_dr,
    input  logic                  shift_dr,
    input  logic                  update_dr,
    input  logic                  tdi,
    output logic                  tdo,
    jtag_stream_bridge_if.master  m,
    input  logic [OUT_WIDTH-1:0]  result,
    input  logic                  result_valid
);
    localparam int CNT_W = bit_cnt_width(IN_WIDTH);
    localparam int TX_W  = OUT_WIDTH + ((STATUS_EN != 0) ? STATUS_WIDTH : 0);

    logic                 clear;
    logic [IN_WIDTH-1:0]  rx;
    logic [TX_W-1:0]      tx;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 overflow;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 push;
    logic                 pop;
    logic [OUT_WIDTH-1:0] result_gated;
    logic [TX_W-1:0]      capture_word;

    assign clear        = !rst_n || test_logic_reset;
    assign result_gated = result_valid ? result : '0;

    generate
        if (STATUS_EN != 0) begin : g_status
            logic [STATUS_WIDTH-1:0] status;
            always_comb begin
                status                  = '0;
                status[ST_RESULT_VALID] = result_valid;
                status[ST_OVERFLOW]     = overflow;
                status[ST_EMPTY]        = fifo_empty;
                status[ST_FULL]         = fifo_full;
            end
            assign capture_word = {status, result_gated};
        end else begin : g_no_status
            assign capture_word = result_gated;
        end
    endgenerate

    // Only a scan of exactly IN_WIDTH bits carries a word; readback and
    // aborted scans leave bit_cnt at some other value.
    assign push = ir_is_user && update_dr && (bit_cnt == CNT_W'(IN_WIDTH));
    assign pop  = m.valid && m.ready;
    assign tdo  = tx[0];

    always_ff @(posedge tck) begin
        if (clear) begin
            rx       <= '0;
            tx       <= '0;
            bit_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            if (ir_is_user) begin
                if (capture_dr) begin
                    bit_cnt <= '0;
                    tx      <= capture_word;
                end else if (shift_dr) begin
                    rx <= {tdi, rx[IN_WIDTH-1:1]};
                    tx <= {1'b0, tx[TX_W-1:1]};
                    if (bit_cnt != CNT_W'(IN_WIDTH + 1)) bit_cnt <= bit_cnt + 1'b1;
                end
            end
            // A pop on the same edge frees the slot, so that push is kept.
            if (push && fifo_full && !pop) overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (IN_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (tck),
        .rst_n     (!clear),
        .push      (push),
        .push_data (rx),
        .pop       (pop),
        .pop_data  (m.data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign m.valid = !fifo_empty;

endmodule

// File: tb/tb_jtag_stream_bridge.sv
module tb_jtag_stream_bridge;

    localparam int IN_W  = 8;
    localparam int OUT_W = 32;
    localparam int DEPTH = 16;
    localparam int TX_W  = OUT_W + 8;

    // clock / reset / TAP signals
    logic             tck = 1'b0;
    logic             rst_n = 1'b0;
    logic             test_logic_reset = 1'b0;
    logic             ir_is_user = 1'b1;
    logic             capture_dr = 1'b0;
    logic             shift_dr = 1'b0;
    logic             update_dr = 1'b0;
    logic             tdi = 1'b0;
    logic             tdo;
    logic [OUT_W-1:0] result = '0;
    logic             result_valid = 1'b0;

    jtag_stream_bridge_if #(.WIDTH(IN_W)) m_if ();

    jtag_stream_bridge #(
        .IN_WIDTH   (IN_W),
        .OUT_WIDTH  (OUT_W),
        .FIFO_DEPTH (DEPTH),
        .STATUS_EN  (1)
    ) dut (
        .tck              (tck),
        .rst_n            (rst_n),
        .test_logic_reset (test_logic_reset),
        .ir_is_user       (ir_is_user),
        .capture_dr       (capture_dr),
        .shift_dr         (shift_dr),
        .update_dr        (update_dr),
        .tdi              (tdi),
        .tdo              (tdo),
        .m                (m_if),
        .result           (result),
        .result_valid     (result_valid)
    );

    always #5 tck = ~tck;

    // scoreboard / reference model state
    int              n_checks = 0;
    int              n_errors = 0;
    logic [IN_W-1:0] exp_q[$];
    logic            model_ovf = 1'b0;
    logic [TX_W-1:0] model_tx = '0;
    logic            pend_push = 1'b0;
    logic [IN_W-1:0] pend_word = '0;
    logic            rand_ready = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_status();
        logic [7:0] s;
        s    = '0;
        s[0] = result_valid;
        s[1] = model_ovf;
        s[2] = (exp_q.size() == 0);
        s[3] = (exp_q.size() == DEPTH);
        return s;
    endfunction

    // One clock: compare outputs at negedge against the model, advance the
    // model by what the current inputs mean, then cross the posedge.
    task automatic tick();
        logic do_pop;
        if (rand_ready) m_if.ready = 1'($urandom_range(0, 1));
        @(negedge tck);
        check("m_valid", m_if.valid, exp_q.size() != 0);
        if (exp_q.size() != 0) check("m_data", m_if.data, exp_q[0]);
        check("tdo", tdo, model_tx[0]);
        if (!rst_n || test_logic_reset) begin
            exp_q.delete();
            model_ovf = 1'b0;
            model_tx  = '0;
        end else begin
            do_pop = m_if.ready && (exp_q.size() != 0);
            if (ir_is_user && capture_dr)
                model_tx = {model_status(), (result_valid ? result : '0)};
            else if (ir_is_user && shift_dr)
                model_tx = model_tx >> 1;
            if (do_pop) void'(exp_q.pop_front());
            if (pend_push) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(pend_word);
                else model_ovf = 1'b1;
            end
        end
        pend_push = 1'b0;
        @(posedge tck);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Full DR scan: capture, n shifts, exit, update. Collects tdo bits.
    task automatic scan(input int n, input logic [63:0] din, input bit ready_at_update,
                        output logic [63:0] dout);
        dout = '0;
        capture_dr = 1'b1;
        tick();
        capture_dr = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i < 64) dout[i] = tdo;
            shift_dr = 1'b1;
            tdi      = (i < 64) ? din[i] : 1'b0;
            tick();
        end
        shift_dr = 1'b0;
        tdi      = 1'b0;
        tick();
        if (ir_is_user && n == IN_W) begin
            pend_push = 1'b1;
            pend_word = din[IN_W-1:0];
        end
        if (ready_at_update) m_if.ready = 1'b1;
        update_dr = 1'b1;
        tick();
        update_dr = 1'b0;
        if (ready_at_update) m_if.ready = 1'b0;
    endtask

    task automatic drain();
        m_if.ready = 1'b1;
        repeat (DEPTH + 4) tick();
        m_if.ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] dout;
        int          len;
        m_if.ready = 1'b0;
        @(posedge tck);
        #1;
        reset_dut();

        // reset values
        check("rst_m_valid", m_if.valid, 0);
        check("rst_m_data", m_if.data, 0);
        check("rst_tdo", tdo, 0);

        // single word '('
        scan(IN_W, 64'h28, 0, dout);
        check("t1_valid", m_if.valid, 1);
        check("t1_data", m_if.data, 8'h28);
        scan(TX_W, 64'h0, 0, dout);
        check("t1_status", dout[39:32], 8'h00);
        drain();

        // overflow: 17 words into 16 slots
        reset_dut();
        for (int i = 0; i < DEPTH + 1; i++) scan(IN_W, 64'(8'hA0 + i), 0, dout);
        result_valid = 1'b0;
        scan(TX_W, 64'h0, 0, dout);
        check("t2_status", dout[39:32], 8'h0A);
        check("t2_head", m_if.data, 8'hA0);
        drain();
        check("t2_empty", m_if.valid, 0);

        // readback scans, no push
        result = 32'h0000_01E3;
        result_valid = 1'b1;
        scan(32, 64'hFFFF_FFFF, 0, dout);
        check("t3_rb_byte0", dout[7:0], 8'hE3);
        check("t3_rb_byte1", dout[15:8], 8'h01);
        check("t3_rb_hi", dout[31:16], 16'h0);
        check("t3_no_push", m_if.valid, 0);
        result_valid = 1'b0;
        scan(32, 64'h0, 0, dout);
        check("t3_rb_zero", dout[31:0], 32'h0);

        // aborted scan cleared by TLR, then a clean word
        reset_dut();
        capture_dr = 1'b1;
        tick();
        capture_dr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            shift_dr = 1'b1;
            tdi = 1'b1;
            tick();
        end
        shift_dr = 1'b0;
        test_logic_reset = 1'b1;
        tick();
        test_logic_reset = 1'b0;
        scan(IN_W, 64'h3E, 0, dout);
        check("t4_data", m_if.data, 8'h3E);
        drain();
        check("t4_one_word", m_if.valid, 0);

        // full FIFO, pop and push on the same edge
        reset_dut();
        for (int i = 0; i < DEPTH; i++) scan(IN_W, 64'(8'h10 + i), 0, dout);
        scan(IN_W, 64'h77, 1, dout);
        scan(TX_W, 64'h0, 0, dout);
        check("t5_status", dout[39:32], 8'h08);
        check("t5_head", m_if.data, 8'h11);
        drain();

        // ir_is_user low: scan ignored
        scan(TX_W, 64'h0, 0, dout);
        ir_is_user = 1'b0;
        scan(IN_W, 64'hFF, 0, dout);
        check("t6_tdo", dout[7:0], 8'h00);
        check("t6_no_push", m_if.valid, 0);
        ir_is_user = 1'b1;
        result = 32'h1;
        result_valid = 1'b1;
        scan(IN_W, 64'h55, 0, dout);
        capture_dr = 1'b1;
        tick();
        capture_dr = 1'b0;
        check("t6_pre_tdo", tdo, 1);
        reset_dut();
        check("t6_rst_valid", m_if.valid, 0);
        check("t6_rst_data", m_if.data, 0);
        check("t6_rst_tdo", tdo, 0);

        // randomized traffic against the model
        rand_ready = 1'b1;
        for (int k = 0; k < 60; k++) begin
            result       = $urandom;
            result_valid = 1'($urandom_range(0, 1));
            ir_is_user   = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 5))
                0, 1, 2: len = IN_W;
                3:       len = TX_W;
                default: len = $urandom_range(1, 12);
            endcase
            scan(len, {$urandom, $urandom}, 0, dout);
            if ($urandom_range(0, 19) == 0) reset_dut();
        end
        rand_ready = 1'b0;
        ir_is_user = 1'b1;
        drain();
        check("final_empty", m_if.valid, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
